quad_updown_gen: RTL

//   Quadrature decoder producing the Up/Down command strobes consumed by the 4-bit up/down counter.

---
 rtl/quad_pkg.sv | 32 +++
 rtl/quad_filter.sv | 43 ++++
 rtl/quad_updown_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Step encodings and Gray-order helpers shared by the quadrature decoder.
package quad_pkg;

  localparam logic [1:0] STEP_NONE = 2'd0;
  localparam logic [1:0] STEP_INC  = 2'd1;
  localparam logic [1:0] STEP_DEC  = 2'd2;
  localparam logic [1:0] STEP_ERR  = 2'd3;

  // Position of {A,B} in the clockwise Gray order 00 -> 01 -> 11 -> 10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] step_of(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] dpos;
    dpos = gray_pos(cur) - gray_pos(prev);
    if (prev == cur)
      return STEP_NONE;
    else if ((prev ^ cur) == 2'b11)
      return STEP_ERR;
    else if (dpos == 2'd1)
      return STEP_INC;
    else
      return STEP_DEC;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder phase: two-flop synchroniser followed by a persistence debounce.
module quad_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Arm,
  input  logic In,
  output logic Filt
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] C_MAX = CW'(FILTER_LEN - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      Filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= In;
      s2 <= s1;
      // During arming the filter follows the synchroniser directly.
      if (Arm) begin
        Filt <= s2;
        cnt  <= '0;
      end else if (s2 == Filt) begin
        cnt <= '0;
      end else if (cnt == C_MAX) begin
        Filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_updown_gen.sv
// Quadrature decoder: filtered A/B phases become one-cycle Up/Down detent strobes,
// with an Error strobe when both phases change in one filtered update.
module quad_updown_gen
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int DETENT     = 4
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic Enable,
  input  logic A,
  input  logic B,
  output logic Up,
  output logic Down,
  output logic Error
);

  localparam int ARM_INIT = 2 + FILTER_LEN;
  localparam int AW       = $clog2(ARM_INIT + 1);
  localparam logic signed [2:0] ACC_MAX = 3'(DETENT - 1);
  localparam logic signed [2:0] ACC_MIN = -ACC_MAX;

  logic [AW-1:0]      arm_cnt;
  logic               arm;
  logic               fa;
  logic               fb;
  logic [1:0]         f;
  logic [1:0]         fd;
  logic [1:0]         step;
  logic signed [2:0]  acc;

  assign arm  = (arm_cnt != '0);
  assign f    = {fa, fb};
  assign step = step_of(fd, f);

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Arm     (arm),
    .In      (A),
    .Filt    (fa)
  );

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Arm     (arm),
    .In      (B),
    .Filt    (fb)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      arm_cnt <= AW'(ARM_INIT);
      fd      <= 2'b00;
      acc     <= '0;
      Up      <= 1'b0;
      Down    <= 1'b0;
      Error   <= 1'b0;
    end else begin
      fd    <= f;
      Up    <= 1'b0;
      Down  <= 1'b0;
      Error <= 1'b0;
      // Arming lets F/Fd settle on the resting encoder position without decoding.
      if (arm) begin
        arm_cnt <= arm_cnt - 1'b1;
        acc     <= '0;
      end else begin
        case (step)
          STEP_ERR: begin
            Error <= 1'b1;
            acc   <= '0;
          end
          STEP_INC: begin
            if (!Enable) begin
              acc <= '0;
            end else if (acc == ACC_MAX) begin
              Up  <= 1'b1;
              acc <= '0;
            end else begin
              acc <= acc + 3'sd1;
            end
          end
          STEP_DEC: begin
            if (!Enable) begin
              acc <= '0;
            end else if (acc == ACC_MIN) begin
              Down <= 1'b1;
              acc  <= '0;
            end else begin
              acc <= acc - 3'sd1;
            end
          end
          default: begin
            if (!Enable) acc <= '0;
          end
        endcase
      end
    end
  end

endmodule
